cacheline_arbiter: RTL and testbench

Shares the single physical-memory port between the icache and dcache miss paths that feed the pipelined datapath's fetch and memory stages.
- Grants one 256-bit cacheline transaction at a time and latches the request for its whole duration.
- Routes the pmem response back to the winner only.
- Default priority is dcache over icache; a starvation limiter bounds how long fetch can be blocked.

---
 rtl/cacheline_arbiter.sv | 169 ++++++++++++++++
 tb/tb_cacheline_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one physical-memory port between the icache and
// dcache miss paths. One 256-bit line transaction is granted at a time. The
// request is latched for its whole duration. The response goes back to the
// winner only. dcache has priority, and a starvation limiter bounds how long
// fetch can be held off.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   icache_pmem_*            icache line-fill request / response
//   dcache_pmem_*            dcache fill/writeback request / response
//   pmem_*                   physical memory port (strobes registered)
//
// Optional: define CACHELINE_ARB_PERF_CTR_EN to add the saturating
// icache_grant_cnt, dcache_grant_cnt and icache_wait_cnt outputs.
module cacheline_arbiter #(
    parameter int LINE_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  icache_pmem_read,
    input  logic [ADDR_WIDTH-1:0] icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [ADDR_WIDTH-1:0] dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
`ifdef CACHELINE_ARB_PERF_CTR_EN
    ,
    output logic [31:0]           icache_grant_cnt,
    output logic [31:0]           dcache_grant_cnt,
    output logic [31:0]           icache_wait_cnt
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] starve_cnt;
    logic       dcache_req;
    logic       starved;
    logic       grant_d;
    logic       grant_i;
    logic       serving;

    assign dcache_req = dcache_pmem_read | dcache_pmem_write;
    assign starved    = (starve_cnt == LIMIT);
    assign serving    = (state == SERVE_I) || (state == SERVE_D);

    // dcache wins unless fetch has waited through LIMIT dcache grants.
    assign grant_d = (state == IDLE) && dcache_req &&
                     !(starved && icache_pmem_read);
    assign grant_i = (state == IDLE) && icache_pmem_read && !grant_d;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = SERVE_D;
                end else if (grant_i) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The memory-side outputs are the latched transaction itself, so no
    // requester input reaches pmem combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                // Read and write together is treated as a writeback.
                pmem_read    <= ~dcache_pmem_write;
                pmem_write   <= dcache_pmem_write;
                pmem_address <= dcache_pmem_address;
                pmem_wdata   <= dcache_pmem_wdata;
            end else if (grant_i) begin
                pmem_read    <= 1'b1;
                pmem_write   <= 1'b0;
                pmem_address <= icache_pmem_address;
            end else if (serving && pmem_resp) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
            end
        end
    end

    // Counts dcache grants taken while fetch waits; any IDLE cycle with
    // no fetch request, or a fetch grant, starts the count over.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_i || !icache_pmem_read) begin
                starve_cnt <= '0;
            end else if (grant_d && !starved) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign icache_pmem_resp  = (state == SERVE_I) && pmem_resp;
    assign dcache_pmem_resp  = (state == SERVE_D) && pmem_resp;
    assign icache_pmem_rdata = pmem_rdata;
    assign dcache_pmem_rdata = pmem_rdata;

`ifdef CACHELINE_ARB_PERF_CTR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            icache_grant_cnt <= '0;
            dcache_grant_cnt <= '0;
            icache_wait_cnt  <= '0;
        end else begin
            if (grant_i && (icache_grant_cnt != 32'hFFFF_FFFF)) begin
                icache_grant_cnt <= icache_grant_cnt + 32'd1;
            end
            if (grant_d && (dcache_grant_cnt != 32'hFFFF_FFFF)) begin
                dcache_grant_cnt <= dcache_grant_cnt + 32'd1;
            end
            if (icache_pmem_read && (state != SERVE_I) &&
                (icache_wait_cnt != 32'hFFFF_FFFF)) begin
                icache_wait_cnt <= icache_wait_cnt + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && (state == IDLE)) begin
            assert (!(dcache_pmem_read && dcache_pmem_write))
            else $warning("dcache read and write both high; issued as write");
        end
    end
`endif

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed bench for cacheline_arbiter. A transaction
// level model predicts the memory-port and response outputs every cycle.
module tb_cacheline_arbiter;

    localparam int LW    = 256;
    localparam int AW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          icache_pmem_read = 1'b0;
    logic [AW-1:0] icache_pmem_address = '0;
    logic [LW-1:0] icache_pmem_rdata;
    logic          icache_pmem_resp;
    logic          dcache_pmem_read = 1'b0;
    logic          dcache_pmem_write = 1'b0;
    logic [AW-1:0] dcache_pmem_address = '0;
    logic [LW-1:0] dcache_pmem_wdata = '0;
    logic [LW-1:0] dcache_pmem_rdata;
    logic          dcache_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    cacheline_arbiter #(
        .LINE_WIDTH(LW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .icache_pmem_read(icache_pmem_read),
        .icache_pmem_address(icache_pmem_address),
        .icache_pmem_rdata(icache_pmem_rdata),
        .icache_pmem_resp(icache_pmem_resp),
        .dcache_pmem_read(dcache_pmem_read),
        .dcache_pmem_write(dcache_pmem_write),
        .dcache_pmem_address(dcache_pmem_address),
        .dcache_pmem_wdata(dcache_pmem_wdata),
        .dcache_pmem_rdata(dcache_pmem_rdata),
        .dcache_pmem_resp(dcache_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    // ---------------- transaction-level model ----------------
    int            m_owner = 0;   // 0 none, 1 icache, 2 dcache
    bit            m_bubble = 0;
    int            m_starve = 0;
    bit            m_wr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [LW-1:0] m_wd = '0;
    int            m_log[$];
    bit            m_ireq;
    bit            m_dwins;

    assign m_ireq  = icache_pmem_read;
    assign m_dwins = (dcache_pmem_read || dcache_pmem_write) &&
                     !(m_ireq && (m_starve >= LIMIT));

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= 0; m_bubble <= 0; m_starve <= 0;
            m_wr <= 0; m_addr <= '0; m_wd <= '0;
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                m_owner <= 0; m_bubble <= 1;
            end
        end else if (m_bubble) begin
            m_bubble <= 0;
        end else if (m_dwins) begin
            m_owner <= 2; m_wr <= dcache_pmem_write;
            m_addr <= dcache_pmem_address; m_wd <= dcache_pmem_wdata;
            m_log.push_back(2);
            if (m_ireq) m_starve <= (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            else m_starve <= 0;
        end else if (m_ireq) begin
            m_owner <= 1; m_wr <= 0; m_addr <= icache_pmem_address;
            m_log.push_back(1);
            m_starve <= 0;
        end else begin
            m_starve <= 0;
        end
    end

    // ---------------- bookkeeping ----------------
    int            errors = 0;
    int            checks = 0;
    int            lat = 3;
    bit            spur = 0;
    int            rcnt = 0;
    int            rd40 = 0;
    int            ev_who[$];
    logic [AW-1:0] ev_addr[$];
    bit            ev_wr[$];
    logic [LW-1:0] ev_wd[$];

    task automatic chk(input string nm, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req_i(input logic [AW-1:0] a, input int budget);
        int n = 0;
        bit got = 0;
        icache_pmem_read = 1'b1;
        icache_pmem_address = a;
        while (!got && n < budget) begin
            @(negedge clk);
            if (icache_pmem_resp) got = 1;
            n++;
        end
        chk("icache_resp_seen", LW'(got), LW'(1));
        step();
        icache_pmem_read = 1'b0;
    endtask

    task automatic req_d(input logic [AW-1:0] a, input logic [LW-1:0] wd,
                         input bit rd, input bit wr, input int nresp,
                         input int budget);
        int n = 0;
        int got = 0;
        dcache_pmem_read = rd;
        dcache_pmem_write = wr;
        dcache_pmem_address = a;
        dcache_pmem_wdata = wd;
        while (got < nresp && n < budget) begin
            @(negedge clk);
            if (dcache_pmem_resp) got++;
            n++;
        end
        chk("dcache_resp_count", LW'(got), LW'(nresp));
        step();
        dcache_pmem_read = 1'b0;
        dcache_pmem_write = 1'b0;
    endtask

    initial begin
        int e0;
        int g0;
        logic [LW-1:0] a5;
        logic [LW-1:0] w5a;
        int seq[7];
        a5 = {32{8'hA5}};
        w5a = {32{8'h5A}};
        seq = '{2, 2, 2, 2, 1, 2, 2};

        fork
            // memory responder: resp after lat cycles of strobe
            forever begin
                @(posedge clk);
                #1;
                pmem_rdata = {8{$urandom}};
                if (pmem_read || pmem_write) rcnt++;
                else rcnt = 0;
                pmem_resp = spur || (rcnt == lat);
            end
            // compare against model + event monitor
            begin
                @(posedge clk);
                forever begin
                    @(negedge clk);
                    chk("pmem_read", LW'(pmem_read),
                        LW'((m_owner != 0) && !m_wr));
                    chk("pmem_write", LW'(pmem_write),
                        LW'((m_owner != 0) && m_wr));
                    chk("pmem_address", LW'(pmem_address), LW'(m_addr));
                    chk("pmem_wdata", pmem_wdata, m_wd);
                    chk("icache_resp", LW'(icache_pmem_resp),
                        LW'((m_owner == 1) && pmem_resp));
                    chk("dcache_resp", LW'(dcache_pmem_resp),
                        LW'((m_owner == 2) && pmem_resp));
                    chk("icache_rdata", icache_pmem_rdata, pmem_rdata);
                    chk("dcache_rdata", dcache_pmem_rdata, pmem_rdata);
                    if (pmem_read && pmem_address == 32'h40) rd40++;
                    if (icache_pmem_resp) begin
                        ev_who.push_back(1); ev_addr.push_back(pmem_address);
                        ev_wr.push_back(pmem_write); ev_wd.push_back(pmem_wdata);
                    end
                    if (dcache_pmem_resp) begin
                        ev_who.push_back(2); ev_addr.push_back(pmem_address);
                        ev_wr.push_back(pmem_write); ev_wd.push_back(pmem_wdata);
                    end
                end
            end
        join_none

        // reset state
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pmem_read", LW'(pmem_read), LW'(0));
        chk("rst_pmem_write", LW'(pmem_write), LW'(0));
        chk("rst_pmem_address", LW'(pmem_address), LW'(0));
        chk("rst_starve", LW'(dut.starve_cnt), LW'(0));
        step();

        // icache-only read, 3-cycle memory latency
        lat = 3;
        e0 = ev_who.size();
        req_i(32'h40, 20);
        repeat (3) step();
        chk("t1_read_cycles", LW'(rd40), LW'(3));
        chk("t1_events", LW'(ev_who.size() - e0), LW'(1));
        if (ev_who.size() > e0) begin
            chk("t1_who", LW'(ev_who[e0]), LW'(1));
            chk("t1_addr", LW'(ev_addr[e0]), LW'(32'h40));
        end

        // simultaneous requests: dcache first
        lat = 2;
        e0 = ev_who.size();
        fork
            req_d(32'h200, '0, 1'b1, 1'b0, 1, 30);
            req_i(32'h100, 30);
        join
        repeat (3) step();
        chk("t2_events", LW'(ev_who.size() - e0), LW'(2));
        if (ev_who.size() >= e0 + 2) begin
            chk("t2_first_who", LW'(ev_who[e0]), LW'(2));
            chk("t2_first_addr", LW'(ev_addr[e0]), LW'(32'h200));
            chk("t2_second_who", LW'(ev_who[e0+1]), LW'(1));
            chk("t2_second_addr", LW'(ev_addr[e0+1]), LW'(32'h100));
        end

        // writeback with requester changing address/wdata mid-serve
        lat = 4;
        e0 = ev_who.size();
        fork
            req_d(32'h300, a5, 1'b0, 1'b1, 1, 30);
            begin
                repeat (2) step();
                dcache_pmem_address = 32'h3C0;
                dcache_pmem_wdata = w5a;
            end
        join
        repeat (3) step();
        chk("t3_events", LW'(ev_who.size() - e0), LW'(1));
        if (ev_who.size() > e0) begin
            chk("t3_wr", LW'(ev_wr[e0]), LW'(1));
            chk("t3_addr", LW'(ev_addr[e0]), LW'(32'h300));
            chk("t3_wdata", ev_wd[e0], a5);
        end

        // starvation limiter: 4 dcache grants, then icache
        lat = 1;
        e0 = ev_who.size();
        g0 = m_log.size();
        fork
            req_d(32'h400, '0, 1'b1, 1'b0, 6, 100);
            req_i(32'h480, 100);
        join
        repeat (3) step();
        chk("t4_events", LW'(ev_who.size() - e0), LW'(7));
        chk("t4_model_grants", LW'(m_log.size() - g0), LW'(7));
        if (ev_who.size() >= e0 + 7 && m_log.size() >= g0 + 7) begin
            for (int k = 0; k < 7; k++) begin
                chk($sformatf("t4_who%0d", k), LW'(ev_who[e0+k]), LW'(seq[k]));
                chk($sformatf("t4_model%0d", k), LW'(m_log[g0+k]), LW'(seq[k]));
            end
        end
        chk("t4_starve_zero", LW'(dut.starve_cnt), LW'(0));

        // reset during SERVE_D
        lat = 20;
        dcache_pmem_read = 1'b1;
        dcache_pmem_address = 32'h600;
        repeat (3) step();
        chk("t5_serving", LW'(pmem_read), LW'(1));
        rst = 1'b1;
        dcache_pmem_read = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_read_off", LW'(pmem_read), LW'(0));
        chk("t5_write_off", LW'(pmem_write), LW'(0));
        chk("t5_state_idle", LW'(dut.state), LW'(0));
        step();
        lat = 2;
        e0 = ev_who.size();
        req_i(32'h500, 30);
        repeat (3) step();
        chk("t5_events", LW'(ev_who.size() - e0), LW'(1));
        if (ev_who.size() > e0) begin
            chk("t5_who", LW'(ev_who[e0]), LW'(1));
            chk("t5_addr", LW'(ev_addr[e0]), LW'(32'h500));
        end

        // spurious resp in IDLE, then read+write together
        e0 = ev_who.size();
        spur = 1'b1;
        step();
        spur = 1'b0;
        repeat (3) step();
        chk("t6_spurious", LW'(ev_who.size() - e0), LW'(0));
        lat = 2;
        req_d(32'h700, a5, 1'b1, 1'b1, 1, 30);
        repeat (3) step();
        chk("t6_events", LW'(ev_who.size() - e0), LW'(1));
        if (ev_who.size() > e0) begin
            chk("t6_who", LW'(ev_who[e0]), LW'(2));
            chk("t6_wr", LW'(ev_wr[e0]), LW'(1));
            chk("t6_addr", LW'(ev_addr[e0]), LW'(32'h700));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
